// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - command-frame to peripheral-bus sequencer (option macro: CMDSEQ_WRITE_ACK_EN)
module cmd_sequencer #(
  parameter int SELECT_CYCLES = 2,
  parameter int MAX_FRAME     = 6
) (
  input  logic         clk_12MHz,
  input  logic         reset_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         frame_start,
  input  logic         frame_end,
  output logic         busy,
  output logic         frame_err,
  output logic [7:0]   register_addr,
  output logic         rw,
  output logic [127:0] select,
  output logic [31:0]  bus_wdata,
  output logic         bus_oe,
  input  logic [31:0]  bus_rdata,
  input  logic [2:0]   reg_size,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready
);

  localparam int CW = $clog2(MAX_FRAME + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_REPLY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    hdr0_q, hdr0_d;
  logic [7:0]    hdr1_q, hdr1_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    size_q, size_d;
  logic [3:0]    sel_cnt_q, sel_cnt_d;
  logic [2:0]    reply_len_q, reply_len_d;
  logic [2:0]    reply_idx_q, reply_idx_d;
  logic          frame_err_q, frame_err_d;
  logic          bus_active;

  // State and datapath registers; reset drops any partial frame or reply
  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      hdr0_q      <= 8'h00;
      hdr1_q      <= 8'h00;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      size_q      <= 3'd0;
      sel_cnt_q   <= 4'd0;
      reply_len_q <= 3'd0;
      reply_idx_q <= 3'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      hdr0_q      <= hdr0_d;
      hdr1_q      <= hdr1_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      sel_cnt_q   <= sel_cnt_d;
      reply_len_q <= reply_len_d;
      reply_idx_q <= reply_idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: frame collection, bus phase sequencing and reply pacing
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    hdr0_d      = hdr0_q;
    hdr1_d      = hdr1_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    sel_cnt_d   = sel_cnt_q;
    reply_len_d = reply_len_q;
    reply_idx_d = reply_idx_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_COLLECT;
          count_d    = '0;
          overflow_d = 1'b0;
          wdata_d    = 32'h0;
        end
      end
      S_COLLECT: begin
        if (frame_start) begin
          count_d    = '0;
          overflow_d = 1'b0;
          wdata_d    = 32'h0;
        end else begin
          // A byte in the same cycle as frame_end is stored before the close check
          if (rx_valid) begin
            if (count_q == CW'(MAX_FRAME)) begin
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
              if (count_q == CW'(0)) hdr0_d = rx_byte;
              if (count_q == CW'(1)) hdr1_d = rx_byte;
              for (int i = 0; i < 4; i++) begin
                if (count_q == CW'(i + 2)) wdata_d[i*8 +: 8] = rx_byte;
              end
            end
          end
          if (frame_end) begin
            if (count_d < CW'(2) || overflow_d) begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d = S_SETUP;
            end
          end
        end
      end
      S_SETUP: begin
        sel_cnt_d = 4'd0;
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        if (sel_cnt_q == 4'(SELECT_CYCLES - 1)) begin
          state_d = S_HOLD;
          if (hdr0_q[7]) begin
            rdata_d = bus_rdata;
            size_d  = (reg_size > 3'd4) ? 3'd4 : reg_size;
          end
        end else begin
          sel_cnt_d = sel_cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        reply_idx_d = 3'd0;
        if (hdr0_q[7]) begin
          reply_len_d = 3'd2 + size_q;
          state_d     = S_REPLY;
        end else begin
`ifdef CMDSEQ_WRITE_ACK_EN
          reply_len_d = 3'd2;
          state_d     = S_REPLY;
`else
          state_d     = S_IDLE;
`endif
        end
      end
      S_REPLY: begin
        if (tx_ready) begin
          if (reply_idx_q == reply_len_q - 3'd1) begin
            state_d = S_IDLE;
          end else begin
            reply_idx_d = reply_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from state so reset clears them immediately
  always_comb begin
    bus_active    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    busy          = bus_active || (state_q == S_REPLY);
    frame_err     = frame_err_q;
    register_addr = bus_active ? hdr1_q : 8'h00;
    rw            = bus_active & hdr0_q[7];
    bus_oe        = bus_active & ~hdr0_q[7];
    bus_wdata     = bus_oe ? wdata_q : 32'h0;
    select        = (state_q == S_STROBE) ? (128'd1 << hdr0_q[6:0]) : 128'd0;
  end

  // Reply byte mux: header bytes first, then read data LSB first
  always_comb begin
    tx_valid = (state_q == S_REPLY);
    tx_byte  = 8'h00;
    if (tx_valid) begin
      case (reply_idx_q)
        3'd0:    tx_byte = hdr0_q;
        3'd1:    tx_byte = hdr1_q;
        3'd2:    tx_byte = rdata_q[7:0];
        3'd3:    tx_byte = rdata_q[15:8];
        3'd4:    tx_byte = rdata_q[23:16];
        3'd5:    tx_byte = rdata_q[31:24];
        default: tx_byte = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - self-checking bench for cmd_sequencer (honours CMDSEQ_WRITE_ACK_EN)
`timescale 1ns/1ps
module tb_cmd_sequencer;
  localparam int SC   = 2;
  localparam int MAXF = 6;

  logic         clk_12MHz = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         frame_end = 1'b0;
  logic         busy;
  logic         frame_err;
  logic [7:0]   register_addr;
  logic         rw;
  logic [127:0] select;
  logic [31:0]  bus_wdata;
  logic         bus_oe;
  logic [31:0]  bus_rdata = 32'h0;
  logic [2:0]   reg_size = 3'd0;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  frm[$];
  logic [7:0]  exp_rep[$];
  logic [31:0] exp_wd;

  cmd_sequencer #(.SELECT_CYCLES(SC), .MAX_FRAME(MAXF)) dut (
    .clk_12MHz(clk_12MHz), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy), .frame_err(frame_err),
    .register_addr(register_addr), .rw(rw), .select(select), .bus_wdata(bus_wdata),
    .bus_oe(bus_oe), .bus_rdata(bus_rdata), .reg_size(reg_size), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #42 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_idle();
    rx_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic junk();
    frame_start = 1'($urandom_range(0, 1));
    frame_end   = 1'($urandom_range(0, 1));
    rx_valid    = 1'($urandom_range(0, 1));
    rx_byte     = 8'($urandom);
  endtask

  // Reference: frame rules turned into expected write data and reply bytes
  task automatic model(input logic [31:0] rd, input logic [2:0] rs);
    int n;
    exp_rep = {};
    exp_wd  = 32'h0;
    for (int i = 2; i < frm.size() && i < 6; i++) exp_wd = exp_wd | (32'(frm[i]) << (8 * (i - 2)));
    if (frm.size() < 2 || frm.size() > MAXF) return;
    if (frm[0][7]) begin
      n = (rs > 3'd4) ? 4 : int'(rs);
      exp_rep.push_back(frm[0]);
      exp_rep.push_back(frm[1]);
      for (int i = 0; i < n; i++) exp_rep.push_back(8'(rd >> (8 * i)));
    end else begin
`ifdef CMDSEQ_WRITE_ACK_EN
      exp_rep.push_back(frm[0]);
      exp_rep.push_back(frm[1]);
`endif
    end
  endtask

  task automatic send_frame(input int pre, input bit end_with_last, input bit gaps);
    @(negedge clk_12MHz); rx_idle(); frame_start = 1'b1;
    for (int i = 0; i < pre; i++) begin
      @(negedge clk_12MHz); rx_idle(); rx_valid = 1'b1; rx_byte = 8'($urandom);
    end
    if (pre > 0) begin
      @(negedge clk_12MHz); rx_idle(); frame_start = 1'b1;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk_12MHz); rx_idle();
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk_12MHz);
      rx_valid = 1'b1; rx_byte = frm[i];
      if (end_with_last && i == frm.size() - 1) frame_end = 1'b1;
    end
    if (!end_with_last || frm.size() == 0) begin
      @(negedge clk_12MHz); rx_idle(); frame_end = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [31:0] rd, input logic [2:0] rs, input int pre,
                           input bit end_with_last, input bit gaps, input bit jk,
                           input int stall_at, input int reset_at);
    bit ok;
    bit rwx;
    logic [127:0] sel_exp;
    int stall_left;
    ok = frm.size() >= 2 && frm.size() <= MAXF;
    model(rd, rs);
    bus_rdata = rd; reg_size = rs;
    send_frame(pre, end_with_last, gaps);
    @(negedge clk_12MHz); rx_idle();
    if (!ok) begin
      chk("err_pulse", frame_err, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_sel", select, 128'd0);
      @(negedge clk_12MHz);
      chk("err_pulse_end", frame_err, 1'b0);
      chk("err_txv", tx_valid, 1'b0);
      chk("err_sel2", select, 128'd0);
      return;
    end
    rwx = frm[0][7];
    sel_exp = 128'd1 << frm[0][6:0];
    if (jk) junk();
    chk("ok_no_err", frame_err, 1'b0);
    chk("setup_busy", busy, 1'b1);
    chk("setup_sel", select, 128'd0);
    chk("setup_addr", register_addr, frm[1]);
    chk("setup_rw", rw, rwx);
    chk("setup_oe", bus_oe, !rwx);
    chk("setup_wdata", bus_wdata, rwx ? 32'h0 : exp_wd);
    for (int c = 0; c < SC; c++) begin
      @(negedge clk_12MHz); if (jk) junk();
      chk("strobe_sel", select, sel_exp);
      chk("strobe_addr", register_addr, frm[1]);
      chk("strobe_oe", bus_oe, !rwx);
      chk("strobe_wdata", bus_wdata, rwx ? 32'h0 : exp_wd);
      chk("strobe_txv", tx_valid, 1'b0);
    end
    @(negedge clk_12MHz); if (jk) junk();
    chk("hold_sel", select, 128'd0);
    chk("hold_addr", register_addr, frm[1]);
    chk("hold_rw", rw, rwx);
    chk("hold_wdata", bus_wdata, rwx ? 32'h0 : exp_wd);
    chk("hold_busy", busy, 1'b1);
    stall_left = 5;
    for (int k = 0; k < exp_rep.size(); ) begin
      @(negedge clk_12MHz); if (jk) junk();
      chk("rep_valid", tx_valid, 1'b1);
      chk("rep_byte", tx_byte, exp_rep[k]);
      chk("rep_sel", select, 128'd0);
      if (k == reset_at) begin
        tx_ready = 1'b0;
        #10 reset_n = 1'b0;
        #1;
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_txbyte", tx_byte, 8'h00);
        @(negedge clk_12MHz); rx_idle(); reset_n = 1'b1;
        return;
      end
      if (k == stall_at && stall_left > 0) begin
        tx_ready = 1'b0; stall_left--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (tx_ready) k++;
    end
    @(negedge clk_12MHz); rx_idle(); tx_ready = 1'b0;
    chk("done_busy", busy, 1'b0);
    chk("done_txv", tx_valid, 1'b0);
    chk("done_sel", select, 128'd0);
  endtask

  initial begin
    int n;
    rx_idle();
    repeat (3) @(negedge clk_12MHz);
    chk("rst_state_busy", busy, 1'b0);
    chk("rst_state_err", frame_err, 1'b0);
    chk("rst_state_sel", select, 128'd0);
    chk("rst_state_oe", bus_oe, 1'b0);
    chk("rst_state_txv", tx_valid, 1'b0);
    chk("rst_state_addr", register_addr, 8'h00);
    reset_n = 1'b1;

    frm = {8'h05, 8'h10, 8'hAA, 8'hBB};
    run_frame(32'hDEADBEEF, 3'd4, 0, 1'b1, 1'b0, 1'b0, -1, -1);

    frm = {8'h83, 8'h02};
    run_frame(32'h12345678, 3'd2, 0, 1'b0, 1'b0, 1'b0, 2, -1);

    frm = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_frame(32'h0, 3'd0, 0, 1'b1, 1'b0, 1'b0, -1, -1);
    frm = {8'h81};
    run_frame(32'h0, 3'd0, 0, 1'b0, 1'b0, 1'b0, -1, -1);

    frm = {8'h81, 8'h00};
    run_frame(32'hA1B2C3D4, 3'd7, 3, 1'b1, 1'b0, 1'b0, -1, -1);

    frm = {8'h83, 8'h02};
    run_frame(32'h12345678, 3'd4, 0, 1'b1, 1'b0, 1'b0, -1, 2);
    frm = {8'h84, 8'h20};
    run_frame(32'hCAFEF00D, 3'd3, 0, 1'b1, 1'b0, 1'b0, -1, -1);

`ifdef CMDSEQ_WRITE_ACK_EN
    frm = {8'h7F, 8'hFF};
    run_frame(32'h0, 3'd0, 0, 1'b1, 1'b0, 1'b0, -1, -1);
`endif

    for (int it = 0; it < 25; it++) begin
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(2, 6));
      frm = {};
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      run_frame($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 2 : 0,
                1'($urandom_range(0, 1)), 1'b1, 1'b1, int'($urandom_range(0, 3)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Sequences the internal peripheral bus from decoded command frames. Sits between the UART frame decoder (unescaped bytes plus start/end markers) and the peripheral bus: it collects one command frame, drives register address, rw, write data and one select line with correct setup/strobe/hold ordering, captures read data and register size, then streams the reply bytes to the UART transmit path. Only one bus transaction is in flight at a time; the block is the sole bus master.

## Interface
- SELECT_CYCLES, 2: cycles the select line is held high (1..15).
- MAX_FRAME, 6: maximum frame length in bytes (header 2 + data 4).

- clk_12MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_byte  in  8  decoded (unescaped) frame byte.
- rx_valid  in  1  rx_byte valid this cycle.
- frame_start  in  1  start-of-frame pulse.
- frame_end  in  1  end-of-frame pulse.
- busy  out  1  high outside IDLE/COLLECT; rx inputs ignored while high.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- register_addr  out  8  bus register address.
- rw  out  1  0 = write, 1 = read.
- select  out  128  one-hot peripheral select.
- bus_wdata  out  32  write data; top drives databus when bus_oe.
- bus_oe  out  1  write-data output enable.
- bus_rdata  in  32  databus as read back.
- reg_size  in  3  register size in bytes from the selected peripheral.
- tx_byte  out  8  reply byte.
- tx_valid  out  1  reply byte valid.
- tx_ready  in  1  transmitter accepts tx_byte.

## Operation
- Frame: byte0 = {rw, periph[6:0]}, byte1 = register address, bytes 2..n-1 = write data, little-endian, zero-extended to 32 bits.
- States: IDLE, COLLECT, SETUP, STROBE, HOLD, REPLY.
- IDLE: frame_start -> COLLECT, count = 0.
- COLLECT: each rx_valid stores the byte at buf[count] and increments count. A byte arriving with count = MAX_FRAME sets overflow. frame_start restarts with count = 0 and no error. frame_end: if count < 2 or overflow, pulse frame_err and go to IDLE; otherwise go to SETUP. rx_valid and frame_end in the same cycle: the byte is stored first, then the frame closes.
- SETUP: drives register_addr and rw. For writes it also drives bus_wdata and bus_oe = 1. select stays all-zero.
- STROBE: select[periph] = 1 for SELECT_CYCLES cycles. For a read, bus_rdata and reg_size are captured on the last STROBE cycle. A reg_size value above 4 is clamped to 4.
- HOLD: select returns to 0 while address, rw and data remain driven for one cycle. Then:
  - read -> REPLY, length 2 + reg_size;
  - write -> IDLE, unless write acknowledge is compiled in.
- REPLY: sends byte0, byte1, then data bytes LSB first. A byte advances only when tx_valid & tx_ready. tx_valid stays high and tx_byte stays stable until accepted. After the last byte, go to IDLE.
- Busy period: frame_start, rx_valid and frame_end are ignored in SETUP, STROBE, HOLD and REPLY.
- Reset (asserted at any time, including mid-reply): all outputs 0, state IDLE, the partial frame is dropped, select is forced to 0 immediately.

## Timing
- frame_end sampled at cycle T.
- SETUP at T+1.
- select high T+2 .. T+1+SELECT_CYCLES.
- HOLD at T+2+SELECT_CYCLES.
- First tx_valid at T+3+SELECT_CYCLES.
- Bus setup before select rise is 1 cycle; hold after select fall is 1 cycle; bus_oe is never high while rw = 1.
- select has at most one bit high in every cycle.
- busy rises at T+1 and falls on the cycle the state returns to IDLE.
- frame_err fires at T+1, only for discarded frames.

## Configuration
- CMDSEQ_WRITE_ACK_EN defined: each write returns a 2-byte reply (byte0, byte1) through REPLY after HOLD.
- Undefined: writes produce no reply bytes, and the block returns to IDLE straight after HOLD.

## Test plan
- Write frame {0x05, 0x10, 0xAA, 0xBB} -> register_addr 0x10, rw 0, bus_wdata 0x0000BBAA with bus_oe 1 one cycle before select[5] rises, select[5] high exactly SELECT_CYCLES cycles, no tx_valid (ack macro off).
- Read frame {0x83, 0x02} with reg_size 2, bus_rdata 0x12345678 -> select[3] pulse, reply 0x83, 0x02, 0x78, 0x56. Hold tx_ready low for 5 cycles mid-reply -> tx_byte stable, no byte lost or duplicated.
- Frame of 7 bytes, and frame of 1 byte -> frame_err pulse, select never asserted, no reply.
- frame_start after 3 bytes, then {0x81, 0x00} -> only the second frame executes; with reg_size 7 the reply is 6 bytes (clamped to 4 data bytes).
- reset_n low during REPLY byte 2 -> tx_valid and busy 0 asynchronously. A following read frame executes normally.
- With CMDSEQ_WRITE_ACK_EN: write {0x7F, 0xFF} -> select[127] pulse, reply 0x7F, 0xFF, bus_wdata 0.
